// File: rtl/relu_seq_ctrl.sv
// relu_seq_ctrl: streams one VEC_SIZE vector through an external LANES-wide relu, chunk by chunk.
// Latency: accept at edge E0 -> out_valid after edge E0+NCHUNK; one vector per NCHUNK+2 cycles.
// Backpressure: in_ready low while RUN/DONE; DONE holds out_vec/clip_cnt until out_ready.
// Optional feature macro: RELU_CLIP_CNT_EN adds the clip_cnt negative-element counter port.
module relu_seq_ctrl #(
  parameter int VEC_SIZE   = 64,
  parameter int DATA_WIDTH = 16,
  parameter int FIXED_PNT  = 8,
  parameter int LANES      = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [DATA_WIDTH*VEC_SIZE-1:0] in_vec,
  output logic [DATA_WIDTH*LANES-1:0]    relu_in,
  input  logic [DATA_WIDTH*LANES-1:0]    relu_out,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [DATA_WIDTH*VEC_SIZE-1:0] out_vec,
  output logic                           busy
`ifdef RELU_CLIP_CNT_EN
  ,
  output logic [$clog2(VEC_SIZE+1)-1:0]  clip_cnt
`endif
);

  localparam int NCHUNK = VEC_SIZE / LANES;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int CHUNKW = DATA_WIDTH * LANES;

  // Parameter sanity: the vector must split into whole chunks.
  if (VEC_SIZE % LANES != 0) begin : g_bad_lanes
    $error("relu_seq_ctrl: VEC_SIZE must be a multiple of LANES");
  end
  if (FIXED_PNT < 0 || FIXED_PNT > DATA_WIDTH) begin : g_bad_fixed
    $error("relu_seq_ctrl: FIXED_PNT must lie within DATA_WIDTH");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                          state, state_nxt;
  logic [IDXW-1:0]                 idx;
  logic [DATA_WIDTH*VEC_SIZE-1:0]  inbuf;
  logic                            rdy_en;
  logic                            accept;
  logic                            last_chunk;

  assign accept     = in_valid && in_ready;
  assign last_chunk = (idx == IDXW'(NCHUNK - 1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = rdy_en;
        if (in_valid && rdy_en) state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_chunk) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // in_ready stays low until the first clock edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdy_en <= 1'b0;
    else        rdy_en <= 1'b1;
  end

  // Current chunk to the relu datapath; zero outside RUN.
  always_comb begin
    relu_in = '0;
    if (state == RUN) relu_in = inbuf[idx*CHUNKW +: CHUNKW];
  end

  // Capture the vector on accept, then walk the chunks writing relu results back.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx     <= '0;
      inbuf   <= '0;
      out_vec <= '0;
    end else if (state == IDLE) begin
      if (accept) begin
        inbuf <= in_vec;
        idx   <= '0;
      end
    end else if (state == RUN) begin
      out_vec[idx*CHUNKW +: CHUNKW] <= relu_out;
      idx <= last_chunk ? '0 : idx + 1'b1;
    end
  end

`ifdef RELU_CLIP_CNT_EN
  localparam int CW = $clog2(VEC_SIZE + 1);

  logic [CW-1:0] neg_cnt;

  // Number of negative lanes in the chunk currently presented to the relu.
  always_comb begin
    neg_cnt = '0;
    for (int l = 0; l < LANES; l++) begin
      neg_cnt = neg_cnt + CW'(relu_in[l*DATA_WIDTH + DATA_WIDTH-1]);
    end
  end

  // Accumulate clipped elements across the RUN cycles of one vector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        clip_cnt <= '0;
    else if (state == IDLE && accept)  clip_cnt <= '0;
    else if (state == RUN)             clip_cnt <= clip_cnt + neg_cnt;
  end
`endif

endmodule

// File: tb/tb_relu_seq_ctrl.sv
// Bench for relu_seq_ctrl with VEC_SIZE=8, LANES=2: directed cases plus random traffic
// against a transaction-level model (countdown of chunks, whole-vector relu at completion).
// Build with RELU_CLIP_CNT_EN defined to also check clip_cnt.
module tb_relu_seq_ctrl;
  localparam int VS  = 8;
  localparam int LN  = 2;
  localparam int DW  = 16;
  localparam int NCH = VS / LN;
  localparam int CW  = $clog2(VS + 1);

  typedef logic [VS*DW-1:0] vec_t;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           out_ready = 1'b0;
  vec_t           in_vec = '0;
  logic           in_ready;
  logic [LN*DW-1:0] relu_in, relu_out;
  logic           out_valid;
  vec_t           out_vec;
  logic           busy;
`ifdef RELU_CLIP_CNT_EN
  logic [CW-1:0]  clip_cnt;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  relu_seq_ctrl #(.VEC_SIZE(VS), .DATA_WIDTH(DW), .FIXED_PNT(8), .LANES(LN)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec),
    .relu_in(relu_in), .relu_out(relu_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_vec(out_vec),
    .busy(busy)
`ifdef RELU_CLIP_CNT_EN
    , .clip_cnt(clip_cnt)
`endif
  );

  // The relu datapath itself: negative lanes become zero.
  always_comb begin
    relu_out = '0;
    for (int l = 0; l < LN; l++) begin
      relu_out[l*DW +: DW] = relu_in[l*DW + DW-1] ? '0 : relu_in[l*DW +: DW];
    end
  end

  task automatic chk(input string nm, input vec_t act, input vec_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    total++;
    bad++;
    $display("FAIL %s: timed out waiting for DUT", nm);
  endtask

  function automatic vec_t pk(input int a[VS]);
    vec_t v;
    for (int i = 0; i < VS; i++) v[i*DW +: DW] = DW'(a[i]);
    return v;
  endfunction

  function automatic vec_t relu_vec(input vec_t v);
    vec_t r;
    logic signed [DW-1:0] e;
    for (int i = 0; i < VS; i++) begin
      e = v[i*DW +: DW];
      r[i*DW +: DW] = (e < 0) ? '0 : e;
    end
    return r;
  endfunction

  function automatic int negs(input vec_t v);
    int n = 0;
    logic signed [DW-1:0] e;
    for (int i = 0; i < VS; i++) begin
      e = v[i*DW +: DW];
      if (e < 0) n++;
    end
    return n;
  endfunction

  // Transaction model: a vector is accepted when idle, occupies NCH cycles,
  // then its whole relu result is offered until out_ready.
  bit   m_started;
  int   m_left;
  bit   m_done;
  vec_t m_lat, m_out;
  int   m_clip;
  int   cyc = 0;
  int   acc_times[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_started = 0; m_left = 0; m_done = 0;
      m_lat = '0; m_out = '0; m_clip = 0;
    end else begin
      cyc++;
      if (m_done) begin
        if (out_ready) m_done = 0;
      end else if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_done = 1;
          m_out  = relu_vec(m_lat);
          m_clip = negs(m_lat);
        end
      end else if (m_started && in_valid) begin
        m_lat  = in_vec;
        m_left = NCH;
        acc_times.push_back(cyc);
      end
      m_started = 1;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    vec_t exp_relu_in;
    exp_relu_in = '0;
    if (m_left > 0) exp_relu_in[LN*DW-1:0] = m_lat[(NCH - m_left)*LN*DW +: LN*DW];
    chk("in_ready",  vec_t'(in_ready),  vec_t'(m_started && m_left == 0 && !m_done));
    chk("busy",      vec_t'(busy),      vec_t'(m_left > 0 || m_done));
    chk("out_valid", vec_t'(out_valid), vec_t'(m_done));
    chk("relu_in",   vec_t'(relu_in),   exp_relu_in);
    if (m_left == 0) begin
      chk("out_vec", out_vec, m_out);
`ifdef RELU_CLIP_CNT_EN
      chk("clip_cnt", vec_t'(clip_cnt), vec_t'(m_clip));
`endif
    end
  end

  task automatic send(input vec_t v, output bit ok);
    bit acc;
    in_vec = v;
    in_valid = 1'b1;
    ok = 0;
    for (int k = 0; k < 60; k++) begin
      acc = in_ready;
      @(posedge clk); #1;
      if (acc) begin ok = 1; break; end
    end
    in_valid = 1'b0;
    if (!ok) timeout("send");
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    if (!out_valid) timeout("wait_valid");
  endtask

  initial begin
    bit ok;
    int n;
    int d1, d2;
    vec_t v;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", vec_t'(out_valid), '0);
    chk("rst_busy",      vec_t'(busy),      '0);
    chk("rst_relu_in",   vec_t'(relu_in),   '0);
    chk("rst_out_vec",   out_vec,           '0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rel_in_ready", vec_t'(in_ready), vec_t'(1));

    // Mixed-sign vector, latency and result.
    out_ready = 1'b1;
    send(pk('{5, -3, 0, 7, -1, 2, -8, 4}), ok);
    wait_valid(n);
    chk("latency", vec_t'(n), vec_t'(NCH));
    chk("vec2_out", out_vec, pk('{5, 0, 0, 7, 0, 2, 0, 4}));
`ifdef RELU_CLIP_CNT_EN
    chk("vec2_clip", vec_t'(clip_cnt), vec_t'(3));
`endif
    repeat (2) @(posedge clk); #1;

    // Backpressure in DONE; a waiting upstream vector must not be taken.
    out_ready = 1'b0;
    send(pk('{-100, 100, 3, -4, 9, -9, 0, 1}), ok);
    wait_valid(n);
    in_valid = 1'b1;
    in_vec = pk('{1, 1, 1, 1, 1, 1, 1, 1});
    for (int k = 0; k < 10; k++) begin
      chk("bp_in_ready",  vec_t'(in_ready),  '0);
      chk("bp_out_valid", vec_t'(out_valid), vec_t'(1));
      chk("bp_out_vec",   out_vec, pk('{0, 100, 3, 0, 9, 0, 0, 1}));
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release", vec_t'(out_valid), '0);
    repeat (2) @(posedge clk); #1;

    // Extremes and all-negative.
    send(pk('{-32768, 32767, -1, 1, -32768, 32767, -1, 1}), ok);
    wait_valid(n);
    chk("ext_out", out_vec, pk('{0, 32767, 0, 1, 0, 32767, 0, 1}));
    @(posedge clk); #1;
    send(pk('{-1, -2, -32768, -5, -7, -300, -32767, -9}), ok);
    wait_valid(n);
    chk("neg_out", out_vec, '0);
`ifdef RELU_CLIP_CNT_EN
    chk("neg_clip", vec_t'(clip_cnt), vec_t'(8));
`endif
    @(posedge clk); #1;

    // Back-to-back with in_valid and out_ready held high.
    acc_times.delete();
    in_valid = 1'b1;
    in_vec = {$urandom, $urandom, $urandom, $urandom};
    for (int k = 0; k < 20; k++) begin
      ok = in_ready;
      @(posedge clk); #1;
      if (ok) in_vec = {$urandom, $urandom, $urandom, $urandom};
    end
    in_valid = 1'b0;
    if (acc_times.size() >= 3) begin
      d1 = acc_times[1] - acc_times[0];
      d2 = acc_times[2] - acc_times[1];
      chk("b2b_gap1", vec_t'(d1), vec_t'(6));
      chk("b2b_gap2", vec_t'(d2), vec_t'(6));
    end else begin
      timeout("b2b_accepts");
    end
    repeat (8) @(posedge clk); #1;

    // Reset in the middle of RUN.
    send(pk('{3, -3, 3, -3, 3, -3, 3, -3}), ok);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("mid_out_valid", vec_t'(out_valid), '0);
    chk("mid_busy",      vec_t'(busy),      '0);
    chk("mid_relu_in",   vec_t'(relu_in),   '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("mid_in_ready", vec_t'(in_ready), vec_t'(1));

    // Random traffic.
    for (int k = 0; k < 600; k++) begin
      in_valid  = ($urandom_range(0, 2) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < VS; i++) begin
        case ($urandom_range(0, 5))
          0:       v[i*DW +: DW] = 16'h8000;
          1:       v[i*DW +: DW] = 16'h7fff;
          2:       v[i*DW +: DW] = 16'h0000;
          default: v[i*DW +: DW] = DW'($urandom);
        endcase
      end
      in_vec = v;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
